// File: rtl/branch_pkg.sv
// Shared constants, entry layout and counter-init helper for the branch resolve/BTB slice.
// Optional build macro BRANCH_PERF_EN is consumed by the top module only.
package branch_pkg;

    localparam int BP_XLEN  = 32;
    localparam int BP_IDX_W = 6;
    localparam int BP_CNT_W = 2;
    localparam int BP_TAG_W = BP_XLEN - BP_IDX_W - 2;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Entry layout for the default geometry (32-bit PC, 64 entries, 2-bit counter).
    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_CNT_W-1:0] cnt;
        logic [BP_XLEN-1:0]  target;
    } btb_entry_t;

    // Jumps start strongly taken, conditional branches weakly taken.
    function automatic int cnt_init(input logic is_jump, input int cnt_w);
        return is_jump ? ((1 << cnt_w) - 1) : (1 << (cnt_w - 1));
    endfunction

endpackage

// File: rtl/branch_btb_table.sv
// Direct-mapped BTB storage: combinational lookup port, one clocked update port,
// synchronous flush of valid bits, async reset of valid bits and counters.
module branch_btb_table
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_lk_pc,
    output logic            o_lk_hit,
    output logic [CNT_W-1:0] o_lk_cnt,
    output logic [XLEN-1:0] o_lk_target,
    input  logic            i_upd_en,
    input  logic [XLEN-1:0] i_upd_pc,
    input  logic            i_upd_taken,
    input  logic            i_upd_jump,
    input  logic [XLEN-1:0] i_upd_target
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [CNT_W-1:0]       r_cnt    [BTB_ENTRIES];
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        r_target [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_unused_pc_lsb;

    assign w_lk_idx = i_lk_pc[IDX_W+1:2];
    assign w_lk_tag = i_lk_pc[XLEN-1:IDX_W+2];
    assign w_up_idx = i_upd_pc[IDX_W+1:2];
    assign w_up_tag = i_upd_pc[XLEN-1:IDX_W+2];
    assign w_unused_pc_lsb = ^{i_lk_pc[1:0], i_upd_pc[1:0]};

    assign o_lk_hit    = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign o_lk_cnt    = r_cnt[w_lk_idx];
    assign o_lk_target = r_target[w_lk_idx];

    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_comb begin
        w_cnt_next = r_cnt[w_up_idx];
        if (w_up_hit) begin
            if (i_upd_taken && (r_cnt[w_up_idx] != CNT_MAX))
                w_cnt_next = r_cnt[w_up_idx] + 1'b1;
            else if (!i_upd_taken && (r_cnt[w_up_idx] != CNT_MIN))
                w_cnt_next = r_cnt[w_up_idx] - 1'b1;
        end else begin
            w_cnt_next = CNT_W'(cnt_init(i_upd_jump, CNT_W));
        end
    end

    // Flush has priority so a concurrent allocation never becomes visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++)
                r_cnt[i] <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_upd_en && (w_up_hit || i_upd_taken)) begin
            r_valid[w_up_idx] <= 1'b1;
            r_cnt[w_up_idx]   <= w_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (i_upd_en && !i_flush && i_upd_taken) begin
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= i_upd_target;
        end
    end

endmodule

// File: rtl/branch_predict_resolve.sv
// EX-stage branch resolution with BTB prediction/training; define BRANCH_PERF_EN
// to add wrap-around branch and mispredict event counters.
module branch_predict_resolve
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int CNT_W       = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btb_flush,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_branch,
    input  logic            ex_jal,
    input  logic            ex_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic            z_flag,
    input  logic            n_flag,
    input  logic            c_flag,
    input  logic            v_flag,
    input  logic            sltu_result,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            ex_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
`ifdef BRANCH_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    logic             w_ctl;
    logic             w_cond;
    logic             w_lk_hit;
    logic [CNT_W-1:0] w_lk_cnt;
    logic [XLEN-1:0]  w_lk_target;
    logic [XLEN-1:0]  w_seq_pc;
    logic             w_unused_carry;

    // The carry flag is not needed: unsigned compares arrive via sltu_result.
    assign w_unused_carry = c_flag;

    assign w_ctl = rst_n & ex_valid & ~ex_stall & (ex_branch | ex_jal | ex_jalr);

    always_comb begin
        w_cond = 1'b0;
        if (ex_jal || ex_jalr) begin
            w_cond = 1'b1;
        end else if (ex_branch) begin
            case (ex_funct3)
                F3_BEQ:  w_cond = z_flag;
                F3_BNE:  w_cond = ~z_flag;
                F3_BLT:  w_cond = n_flag ^ v_flag;
                F3_BGE:  w_cond = ~(n_flag ^ v_flag);
                F3_BLTU: w_cond = sltu_result;
                F3_BGEU: w_cond = ~sltu_result;
                default: w_cond = 1'b0;
            endcase
        end
    end

    assign w_seq_pc    = ex_pc + XLEN'(4);
    assign ex_taken    = w_ctl & w_cond;
    assign redirect    = w_ctl & ((w_cond != ex_pred_taken) |
                                  (w_cond & (ex_target != ex_pred_target)));
    assign redirect_pc = !rst_n ? '0 : (w_cond ? ex_target : w_seq_pc);

    assign pred_taken  = w_lk_hit & w_lk_cnt[CNT_W-1];
    assign pred_target = w_lk_hit ? w_lk_target : '0;

    branch_btb_table #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CNT_W       (CNT_W)
    ) u_table (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (btb_flush),
        .i_lk_pc      (if_pc),
        .o_lk_hit     (w_lk_hit),
        .o_lk_cnt     (w_lk_cnt),
        .o_lk_target  (w_lk_target),
        .i_upd_en     (w_ctl),
        .i_upd_pc     (ex_pc),
        .i_upd_taken  (w_cond),
        .i_upd_jump   (ex_jal | ex_jalr),
        .i_upd_target (ex_target)
    );

`ifdef BRANCH_PERF_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else begin
            if (w_ctl)
                r_perf_branches <= r_perf_branches + 32'd1;
            if (redirect)
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Randomized self-checking bench for branch_predict_resolve against a behavioural BTB model.
module tb_branch_predict_resolve;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btb_flush = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0, ex_stall = 1'b0;
    logic        ex_branch = 1'b0, ex_jal = 1'b0, ex_jalr = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic        z_flag = 1'b0, n_flag = 1'b0, c_flag = 1'b0, v_flag = 1'b0, sltu_result = 1'b0;
    logic [31:0] ex_pc = '0, ex_target = '0, ex_pred_target = '0;
    logic        ex_pred_taken = 1'b0;
    logic        ex_taken, redirect;
    logic [31:0] redirect_pc;
`ifdef BRANCH_PERF_EN
    logic [31:0] perf_branches, perf_mispredicts;
    int unsigned m_pb = 0, m_pm = 0;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural table: index and tag derived arithmetically from the PC.
    bit          mv  [64];
    int          mc  [64];
    logic [31:0] mt  [64];
    logic [31:0] mtg [64];

    branch_predict_resolve dut (
        .clk(clk), .rst_n(rst_n), .btb_flush(btb_flush), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch),
        .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_funct3(ex_funct3),
        .z_flag(z_flag), .n_flag(n_flag), .c_flag(c_flag), .v_flag(v_flag),
        .sltu_result(sltu_result), .ex_pc(ex_pc), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .ex_taken(ex_taken), .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef BRANCH_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int ix(input logic [31:0] pc);
        return int'((pc / 4) % 64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return mv[ix(pc)] && (mt[ix(pc)] == pc / 256);
    endfunction

    function automatic bit m_pt(input logic [31:0] pc);
        return m_hit(pc) && (mc[ix(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptg(input logic [31:0] pc);
        return m_hit(pc) ? mtg[ix(pc)] : 32'd0;
    endfunction

    function automatic bit m_cond();
        if (ex_jal || ex_jalr) return 1'b1;
        if (!ex_branch) return 1'b0;
        case (ex_funct3)
            3'd0: return z_flag;
            3'd1: return !z_flag;
            3'd4: return n_flag != v_flag;
            3'd5: return n_flag == v_flag;
            3'd6: return sltu_result;
            3'd7: return !sltu_result;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_ctl();
        return ex_valid && !ex_stall && (ex_branch || ex_jal || ex_jalr);
    endfunction

    function automatic bit m_redirect();
        return m_ctl() && ((m_cond() != ex_pred_taken) || (m_cond() && ex_target != ex_pred_target));
    endfunction

    function automatic logic [31:0] m_rpc();
        return m_cond() ? ex_target : ex_pc + 32'd4;
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit t, input bit j, input logic [31:0] tg);
        int i;
        i = ix(pc);
        if (m_hit(pc)) begin
            if (t) begin
                mc[i]  = (mc[i] < 3) ? mc[i] + 1 : 3;
                mtg[i] = tg;
            end else begin
                mc[i] = (mc[i] > 0) ? mc[i] - 1 : 0;
            end
        end else if (t) begin
            mv[i] = 1'b1; mt[i] = pc / 256; mtg[i] = tg; mc[i] = j ? 3 : 2;
        end
    endfunction

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0; mc[i] = 0;
        end
    endfunction

    task automatic drive(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                         input bit z, input bit n, input bit v, input bit s,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input bit pt, input logic [31:0] ppt, input bit stall);
        ex_valid = 1'b1; ex_branch = br; ex_jal = jal; ex_jalr = jalr; ex_funct3 = f3;
        z_flag = z; n_flag = n; v_flag = v; sltu_result = s; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pt; ex_pred_target = ppt; ex_stall = stall;
        #1;
    endtask

    task automatic commit();
        bit c, t, j, f;
        logic [31:0] pc, tg;
        c = m_ctl(); t = m_cond(); j = ex_jal || ex_jalr; f = btb_flush; pc = ex_pc; tg = ex_target;
`ifdef BRANCH_PERF_EN
        if (c) m_pb++;
        if (m_redirect()) m_pm++;
`endif
        @(posedge clk);
        if (f) begin
            for (int i = 0; i < 64; i++) mv[i] = 1'b0;
        end else if (c) begin
            m_update(pc, t, j, tg);
        end
        #1;
        ex_valid = 1'b0; ex_stall = 1'b0; btb_flush = 1'b0;
    endtask

    task automatic test_reset();
        m_clear();
        rst_n = 1'b0;
        drive(1, 0, 0, 3'd0, 1, 0, 0, 0, 32'h100, 32'h80, 0, 32'h0, 0);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL reset_pred_target: got %h want 0", pred_target); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect: got %0b want 0", redirect); end
        checks++; if (ex_taken !== 1'b0) begin errors++; $display("FAIL reset_ex_taken: got %0b want 0", ex_taken); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
    endtask

    task automatic test_beq_alloc();
        if_pc = 32'h100;
        drive(1, 0, 0, 3'd0, 1, 0, 0, 0, 32'h100, 32'h80, 0, 32'h0, 0);
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_cold_pred: got %0b want 0", pred_taken); end
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %0b want 1", redirect); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL beq_redirect_pc: got %h want 80", redirect_pc); end
        checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL beq_ex_taken: got %0b want 1", ex_taken); end
        commit();
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_alloc_pred: got %0b want 1", pred_taken); end
        checks++; if (pred_target !== 32'h80) begin errors++; $display("FAIL beq_alloc_target: got %h want 80", pred_target); end
    endtask

    task automatic test_saturate();
        if_pc = 32'h100;
        drive(1, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100, 32'h80, 1, 32'h80, 0);
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL sat_nt1_redirect: got %0b want 1", redirect); end
        checks++; if (redirect_pc !== 32'h104) begin errors++; $display("FAIL sat_nt1_pc: got %h want 104", redirect_pc); end
        commit();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_cnt1_pred: got %0b want 0", pred_taken); end
        drive(1, 0, 0, 3'd0, 0, 0, 0, 0, 32'h100, 32'h80, 0, 32'h0, 0);
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL sat_nt2_redirect: got %0b want 0", redirect); end
        commit();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_cnt0_pred: got %0b want 0", pred_taken); end
        drive(1, 0, 0, 3'd0, 1, 0, 0, 0, 32'h100, 32'h80, 0, 32'h0, 0);
        commit();
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor_pred: got %0b want 0", pred_taken); end
    endtask

    task automatic test_conditions();
        drive(1, 0, 0, 3'd4, 0, 0, 1, 0, 32'h1000, 32'h900, 0, 32'h0, 0);
        checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL blt_overflow: got %0b want 1", ex_taken); end
        commit();
        drive(1, 0, 0, 3'd5, 0, 1, 1, 0, 32'h1004, 32'h900, 0, 32'h0, 0);
        checks++; if (ex_taken !== 1'b1) begin errors++; $display("FAIL bge_nv: got %0b want 1", ex_taken); end
        commit();
        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 3'(i % 8), 1'($urandom), 1'($urandom), 1'($urandom), 1'(i / 8),
                  32'h1100 + 32'(i * 4), 32'h2000, 0, 32'h0, 0);
            checks++; if (ex_taken !== m_cond()) begin errors++; $display("FAIL cond_f3_%0d: got %0b want %0b", i % 8, ex_taken, m_cond()); end
            commit();
        end
        drive(1, 0, 0, 3'd1, 1, 0, 0, 0, 32'hFFFF_FFFC, 32'h40, 0, 32'h0, 0);
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL pc_wrap: got %h want 0", redirect_pc); end
        commit();
    endtask

    task automatic test_jalr_alias();
        drive(0, 0, 1, 3'd0, 0, 0, 0, 0, 32'h200, 32'h300, 0, 32'h0, 0);
        commit();
        if_pc = 32'h100;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_evict_pred: got %0b want 0", pred_taken); end
        checks++; if (pred_target !== 32'h0) begin errors++; $display("FAIL alias_evict_target: got %h want 0", pred_target); end
        drive(0, 0, 1, 3'd0, 0, 0, 0, 0, 32'h200, 32'h340, 1, 32'h300, 0);
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jalr_redirect: got %0b want 1", redirect); end
        checks++; if (redirect_pc !== 32'h340) begin errors++; $display("FAIL jalr_redirect_pc: got %h want 340", redirect_pc); end
        commit();
        if_pc = 32'h200;
        #1;
        checks++; if (pred_target !== 32'h340) begin errors++; $display("FAIL jalr_target_upd: got %h want 340", pred_target); end
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL jalr_pred: got %0b want 1", pred_taken); end
    endtask

    task automatic test_stall();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 3'd0, 0, 0, 0, 0, 32'h200, 32'h340, 1, 32'h340, 1);
            checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL stall_redirect: got %0b want 0", redirect); end
            checks++; if (ex_taken !== 1'b0) begin errors++; $display("FAIL stall_ex_taken: got %0b want 0", ex_taken); end
            commit();
        end
        if_pc = 32'h200;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL stall_no_train: got %0b want 1", pred_taken); end
    endtask

    task automatic test_flush();
        btb_flush = 1'b1;
        drive(1, 0, 0, 3'd0, 1, 0, 0, 0, 32'h300, 32'h500, 0, 32'h0, 0);
        commit();
        if_pc = 32'h300;
        #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL flush_update: got %0b/%h want 0/0", pred_taken, pred_target); end
        if_pc = 32'h200;
        #1;
        checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin errors++; $display("FAIL flush_other: got %0b/%h want 0/0", pred_taken, pred_target); end
    endtask

    task automatic test_random();
        logic [31:0] pcs [8] = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h3000, 32'h3100, 32'hFFFF_FFFC};
        logic [31:0] tgs [4] = '{32'h80, 32'h400, 32'h800, 32'h1234};
        int k;
        for (int it = 0; it < 400; it++) begin
            k = int'($urandom_range(0, 9));
            ex_valid = ($urandom_range(0, 9) != 0);
            ex_stall = ($urandom_range(0, 9) == 0);
            btb_flush = ($urandom_range(0, 29) == 0);
            ex_jal = (k == 0); ex_jalr = (k == 1); ex_branch = (k >= 2 && k <= 8) || (k == 1 && $urandom_range(0, 1) == 1);
            ex_funct3 = 3'($urandom); z_flag = 1'($urandom); n_flag = 1'($urandom);
            c_flag = 1'($urandom); v_flag = 1'($urandom); sltu_result = 1'($urandom);
            ex_pc = pcs[$urandom_range(0, 7)]; ex_target = tgs[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) != 0) begin
                ex_pred_taken = m_pt(ex_pc); ex_pred_target = m_ptg(ex_pc);
            end else begin
                ex_pred_taken = 1'($urandom); ex_pred_target = tgs[$urandom_range(0, 3)];
            end
            if_pc = ($urandom_range(0, 1) == 1) ? ex_pc : pcs[$urandom_range(0, 7)];
            #1;
            checks++; if (pred_taken !== m_pt(if_pc)) begin errors++; $display("FAIL rnd_pred_taken it=%0d pc=%h: got %0b want %0b", it, if_pc, pred_taken, m_pt(if_pc)); end
            checks++; if (pred_target !== m_ptg(if_pc)) begin errors++; $display("FAIL rnd_pred_target it=%0d pc=%h: got %h want %h", it, if_pc, pred_target, m_ptg(if_pc)); end
            checks++; if (ex_taken !== (m_ctl() && m_cond())) begin errors++; $display("FAIL rnd_ex_taken it=%0d: got %0b want %0b", it, ex_taken, m_ctl() && m_cond()); end
            checks++; if (redirect !== m_redirect()) begin errors++; $display("FAIL rnd_redirect it=%0d: got %0b want %0b", it, redirect, m_redirect()); end
            if (m_ctl()) begin
                checks++; if (redirect_pc !== m_rpc()) begin errors++; $display("FAIL rnd_redirect_pc it=%0d: got %h want %h", it, redirect_pc, m_rpc()); end
            end
            commit();
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 3'd0, 0, 0, 0, 0, 32'h3000, 32'h800, 0, 32'h0, 0);
        commit();
        if_pc = 32'h3000;
        #1;
        checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pre_reset_pred: got %0b want 1", pred_taken); end
        drive(1, 0, 0, 3'd0, 1, 0, 0, 0, 32'h3000, 32'h900, 0, 32'h0, 0);
        rst_n = 1'b0;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL mid_reset_pred: got %0b want 0", pred_taken); end
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL mid_reset_redirect: got %0b/%h want 0/0", redirect, redirect_pc); end
        ex_valid = 1'b0;
        m_clear();
`ifdef BRANCH_PERF_EN
        m_pb = 0; m_pm = 0;
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL post_reset_pred: got %0b want 0", pred_taken); end
    endtask

`ifdef BRANCH_PERF_EN
    task automatic test_perf();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 3'd0, (i < 3), 0, 0, 0, 32'h4000 + 32'(i * 4), 32'h80, 0, 32'h0, 0);
            commit();
        end
        checks++; if (perf_branches !== m_pb) begin errors++; $display("FAIL perf_branches: got %0d want %0d", perf_branches, m_pb); end
        checks++; if (perf_mispredicts !== m_pm) begin errors++; $display("FAIL perf_mispredicts: got %0d want %0d", perf_mispredicts, m_pm); end
    endtask
`endif

    initial begin
        test_reset();
        test_beq_alloc();
        test_saturate();
        test_conditions();
        test_jalr_alias();
        test_stall();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef BRANCH_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
